// File: rtl/shift_pkg.sv
// Shared op-code and FSM state encodings for the shift unit and the ALU decoder.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_LSL  = 3'b000,
        OP_LSR  = 3'b001,
        OP_ASR  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_SSL  = 3'b101,
        OP_SSR  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
// Rotates exist only when SHIFT_UNIT_ROTATE_EN is defined; otherwise ROL/ROR fall back to LSL/LSR.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value_i,
    input  op_e              op_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] next_o,
    output logic             exit_o
);

    always_comb begin
        next_o = value_i;
        exit_o = 1'b0;
        case (op_i)
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_LSL: begin
`else
            OP_LSL, OP_ROL: begin
`endif
                next_o = {value_i[WIDTH-2:0], 1'b0};
                exit_o = value_i[WIDTH-1];
            end
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_LSR: begin
`else
            OP_LSR, OP_ROR: begin
`endif
                next_o = {1'b0, value_i[WIDTH-1:1]};
                exit_o = value_i[0];
            end
            OP_ASR: begin
                next_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
                exit_o = value_i[0];
            end
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROL: begin
                next_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
                exit_o = value_i[WIDTH-1];
            end
            OP_ROR: begin
                next_o = {value_i[0], value_i[WIDTH-1:1]};
                exit_o = value_i[0];
            end
`endif
            OP_SSL: begin
                next_o = {value_i[WIDTH-2:0], serial_i};
                exit_o = value_i[WIDTH-1];
            end
            OP_SSR: begin
                next_o = {serial_i, value_i[WIDTH-1:1]};
                exit_o = value_i[0];
            end
            default: begin
                next_o = value_i;
                exit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate register: one single-bit step per clock under start/busy/done.
// Optional rotate support via SHIFT_UNIT_ROTATE_EN.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    input  logic             serial_in,
    output logic [WIDTH-1:0] dout,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] WIDTH_CNT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE_CNT   = AMT_W'(1);

    state_e             state_q, state_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               carry_q, carry_d;

    logic [WIDTH-1:0]   step_val;
    logic               step_exit;
    logic [AMT_W-1:0]   start_cnt;

    // PASS forces a zero count; anything beyond WIDTH saturates
    function automatic logic [AMT_W-1:0] eff_count(input logic [2:0] o,
                                                   input logic [AMT_W-1:0] a);
        if (o == OP_PASS) return '0;
        return (a > WIDTH_CNT) ? WIDTH_CNT : a;
    endfunction

    assign start_cnt = eff_count(op, amt);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value_i  (dout_q),
        .op_i     (op_q),
        .serial_i (serial_in),
        .next_o   (step_val),
        .exit_o   (step_exit)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LSL;
            dout_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dout_q  <= dout_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (start_cnt != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt_q == ONE_CNT) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        dout_d  = dout_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = start_cnt;
                    op_d    = op_e'(op);
                    dout_d  = din;
                    carry_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                cnt_d   = cnt_q - ONE_CNT;
                dout_d  = step_val;
                carry_d = step_exit;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        dout      = dout_q;
        carry_out = carry_q;
    end

endmodule
